spi_rx_16: RTL and testbench
============================

Name: spi_rx_16

Overview:
- Receive-side counterpart of spi_16. Deserialises the mosi/cs_n stream from spi_16 back into parallel words on the same system clock.
- Words are presented on a valid/ready output port for downstream OFDM test logic, used for loopback checks of the transmitter.
- Detects short and long frames, and detects overrun when a completed word cannot be delivered.

Parameters:
- DATA_W, 16, word width in bits, equal to the frame length in sclk cycles.
- MSB_FIRST, 1, 1 = first received bit is data_out[DATA_W-1]; 0 = first bit is data_out[0].

Ports:
- sclk  input  1  system clock; all logic on rising edge.
- reset_n  input  1  asynchronous active-low reset.
- mosi  input  1  serial data from spi_16.
- cs_n  input  1  frame enable, active low.
- data_out  output  DATA_W  received word, held stable while data_valid=1.
- data_valid  output  1  word available.
- data_ready  input  1  consumer accepts the word when data_valid=1 and data_ready=1 on a sclk edge.
- frame_err  output  1  one-cycle pulse on a short or long frame.
- overrun  output  1  one-cycle pulse when a completed word is dropped.

Behaviour:
- Reset (async assert, sync-safe release):
  - data_out=0, data_valid=0, frame_err=0, overrun=0.
  - Shift register=0, bit counter=0, state=IDLE.
- Bit sampling: one bit per sclk edge on which the sampled cs_n is 0 (cs_n_s, mosi_s; raw inputs unless SPI_RX_SYNC_EN).
- Bit counter width is $clog2(DATA_W+1).
- FSM states: IDLE, SHIFT, TAIL.
  - IDLE, cs_n_s=0: capture mosi_s as bit 0, cnt=1, go to SHIFT.
  - SHIFT, cs_n_s=0, cnt<DATA_W-1: shift in mosi_s, cnt++.
  - SHIFT, cs_n_s=0, cnt==DATA_W-1: shift in the last bit and commit the word on this same edge, go to TAIL.
  - SHIFT, cs_n_s=1 (short frame): pulse frame_err, discard partial word, cnt=0, go to IDLE.
  - TAIL, cs_n_s=1: go to IDLE; the next frame may start on the following low cycle. A minimum gap of 1 cycle high is required.
  - TAIL, cs_n_s=0 (long frame): ignore the extra bits. Pulse frame_err once, on the first extra cycle only. Stay in TAIL until cs_n_s=1.
- Bit order:
  - MSB_FIRST=1: shift left, new bit enters the LSB.
  - MSB_FIRST=0: shift right, new bit enters the MSB.
- Latency: data_valid=1 and data_out are visible in the cycle after the edge that samples bit DATA_W-1 (+2 cycles with SPI_RX_SYNC_EN).
- Output handshake, evaluated on each commit edge:
  - Commit with data_valid=0, or with data_valid=1 and data_ready=1: load data_out with the new word, data_valid=1.
  - Commit with data_valid=1 and data_ready=0: drop the new word, keep data_out, pulse overrun.
  - No commit, data_valid=1 and data_ready=1: data_valid=0, data_out holds its last value.
- data_ready is ignored while data_valid=0.
- Reset mid-frame: partial word is lost, outputs return to reset values immediately. After release, reception starts only at the next low cs_n seen in IDLE. If cs_n is already low at release, the frame is received from that cycle and is likely short or misaligned; frame_err is then flagged as the rules above require.
- frame_err and overrun can both pulse in the same cycle only when long-frame and commit rules coincide (they cannot by construction); each is an independent registered pulse.

Optional Feature:
- Macro SPI_RX_SYNC_EN.
- Defined: cs_n and mosi each pass through a 2-flop synchroniser clocked by sclk. The cs_n synchroniser flops reset to 1, the mosi flops reset to 0. All behaviour is otherwise identical, with 2 extra cycles of latency.
- Undefined: inputs are used directly. This is only valid when the transmitter is on the same sclk, as spi_16 is.

Decomposition:
- Shared package ofdm_spi_pkg:
  - DATA_W default constant (16).
  - FSM state encoding constants SPI_RX_IDLE, SPI_RX_SHIFT, SPI_RX_TAIL.
  - Counter width function.
- One sub-module: spi_rx_sync, the 2-flop synchroniser with a reset-value parameter. It is instantiated only under SPI_RX_SYNC_EN.

Test Plan:
- Basic word: reset 50 ns, then one frame of 16'hA5C3 MSB-first with data_ready=1 → data_valid pulses 1 cycle, data_out=16'hA5C3, frame_err=0, overrun=0.
- Back-to-back words: feed spi_16 with data_in 16'hFFFF, 16'hFFF0, 16'hFF0F, 16'hF0FF, 16'h0FFF at 180 ns spacing (2 cycles cs_n high between frames), data_ready=1 → five words received in order, matching exactly.
- Short frame: cs_n low 10 cycles, then high → frame_err pulses 1 cycle on the rising cs_n sample, no data_valid. A following good frame of 16'h1234 is received correctly.
- Long frame: cs_n low 20 cycles carrying 16'hBEEF followed by 4 junk bits → data_out=16'hBEEF, data_valid=1, and a single frame_err pulse on cycle 17.
- Overrun: with data_ready=0, send 16'h0001, then 16'h0002 → data_out stays 16'h0001 and overrun pulses once. Raise data_ready → data_valid drops next cycle.
- Reset and bit order:
  - reset_n low at bit 8 of a frame → outputs go to 0 immediately; after release, the next full frame 16'h5A5A is correct.
  - With MSB_FIRST=0, sending bits of 16'h0001 LSB-first gives data_out=16'h0001.

Source files
------------

// File: rtl/ofdm_spi_pkg.sv
// rtl/ofdm_spi_pkg.sv - shared constants, FSM encoding and helpers for the SPI loopback receiver
package ofdm_spi_pkg;

  localparam int SPI_DATA_W = 16;

  localparam logic [1:0] SPI_RX_IDLE  = 2'd0;
  localparam logic [1:0] SPI_RX_SHIFT = 2'd1;
  localparam logic [1:0] SPI_RX_TAIL  = 2'd2;

  function automatic int spi_cnt_w(input int data_w);
    return $clog2(data_w + 1);
  endfunction

endpackage

// File: rtl/spi_rx_sync.sv
// rtl/spi_rx_sync.sv - 2-flop input synchroniser with a configurable reset value
module spi_rx_sync #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic sclk,
  input  logic reset_n,
  input  logic d_i,
  output logic q_o
);

  logic [1:0] ff_q;

  always_ff @(posedge sclk or negedge reset_n) begin
    if (!reset_n) begin
      ff_q <= {2{RST_VAL}};
    end else begin
      ff_q <= {ff_q[0], d_i};
    end
  end

  assign q_o = ff_q[1];

endmodule

// File: rtl/spi_rx_16.sv
// rtl/spi_rx_16.sv - SPI frame deserialiser with valid/ready output and frame/overrun flags
// Optional macro SPI_RX_SYNC_EN adds 2-flop synchronisers on cs_n and mosi.
module spi_rx_16
  import ofdm_spi_pkg::*;
#(
  parameter int DATA_W    = SPI_DATA_W,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic              sclk,
  input  logic              reset_n,
  input  logic              mosi,
  input  logic              cs_n,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  input  logic              data_ready,
  output logic              frame_err,
  output logic              overrun
);

  localparam int CW = spi_cnt_w(DATA_W);

  logic cs_n_s;
  logic mosi_s;

`ifdef SPI_RX_SYNC_EN
  spi_rx_sync #(.RST_VAL(1'b1)) u_cs_sync (
    .sclk    (sclk),
    .reset_n (reset_n),
    .d_i     (cs_n),
    .q_o     (cs_n_s)
  );
  spi_rx_sync #(.RST_VAL(1'b0)) u_mosi_sync (
    .sclk    (sclk),
    .reset_n (reset_n),
    .d_i     (mosi),
    .q_o     (mosi_s)
  );
`else
  assign cs_n_s = cs_n;
  assign mosi_s = mosi;
`endif

  logic [1:0]        state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [DATA_W-1:0] sh_q, sh_d;
  logic              long_q, long_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic              valid_q, valid_d;
  logic              ferr_q, ferr_d;
  logic              ovr_q, ovr_d;
  logic              commit;

  function automatic logic [DATA_W-1:0] shift_in(input logic [DATA_W-1:0] cur, input logic b);
    if (MSB_FIRST) begin
      return {cur[DATA_W-2:0], b};
    end else begin
      return {b, cur[DATA_W-1:1]};
    end
  endfunction

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sh_d    = sh_q;
    long_d  = long_q;
    ferr_d  = 1'b0;
    commit  = 1'b0;
    case (state_q)
      SPI_RX_IDLE: begin
        if (!cs_n_s) begin
          sh_d    = shift_in('0, mosi_s);
          cnt_d   = CW'(1);
          state_d = SPI_RX_SHIFT;
        end
      end
      SPI_RX_SHIFT: begin
        if (cs_n_s) begin
          ferr_d  = 1'b1;
          sh_d    = '0;
          cnt_d   = '0;
          state_d = SPI_RX_IDLE;
        end else begin
          sh_d = shift_in(sh_q, mosi_s);
          if (cnt_q == CW'(DATA_W - 1)) begin
            commit  = 1'b1;
            cnt_d   = '0;
            long_d  = 1'b0;
            state_d = SPI_RX_TAIL;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      SPI_RX_TAIL: begin
        if (cs_n_s) begin
          long_d  = 1'b0;
          state_d = SPI_RX_IDLE;
        end else if (!long_q) begin
          // only the first surplus bit of a long frame is flagged
          ferr_d = 1'b1;
          long_d = 1'b1;
        end
      end
      default: begin
        state_d = SPI_RX_IDLE;
        cnt_d   = '0;
        sh_d    = '0;
        long_d  = 1'b0;
      end
    endcase
  end

  always_comb begin
    dout_d  = dout_q;
    valid_d = valid_q;
    ovr_d   = 1'b0;
    if (commit) begin
      if (!valid_q || data_ready) begin
        dout_d  = sh_d;
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end else if (valid_q && data_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge sclk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= SPI_RX_IDLE;
      cnt_q   <= '0;
      sh_q    <= '0;
      long_q  <= 1'b0;
      dout_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
      long_q  <= long_d;
      dout_q  <= dout_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
    end
  end

  assign data_out   = dout_q;
  assign data_valid = valid_q;
  assign frame_err  = ferr_q;
  assign overrun    = ovr_q;

endmodule

// File: tb/tb_spi_rx_16.sv
// tb/tb_spi_rx_16.sv - directed self-checking bench for spi_rx_16 (MSB-first and LSB-first instances)
module tb_spi_rx_16;

  logic        sclk = 1'b0;
  logic        reset_n = 1'b0;
  logic        mosi = 1'b0;
  logic        cs_n = 1'b1;
  logic        data_ready = 1'b1;
  logic [15:0] d1, d2;
  logic        v1, v2, fe1, fe2, ov1, ov2;

  int n_cmp = 0;
  int n_err = 0;

  always #5 sclk = ~sclk;

  spi_rx_16 #(.DATA_W(16), .MSB_FIRST(1'b1)) u_msb (
    .sclk       (sclk),
    .reset_n    (reset_n),
    .mosi       (mosi),
    .cs_n       (cs_n),
    .data_out   (d1),
    .data_valid (v1),
    .data_ready (data_ready),
    .frame_err  (fe1),
    .overrun    (ov1)
  );

  spi_rx_16 #(.DATA_W(16), .MSB_FIRST(1'b0)) u_lsb (
    .sclk       (sclk),
    .reset_n    (reset_n),
    .mosi       (mosi),
    .cs_n       (cs_n),
    .data_out   (d2),
    .data_valid (v2),
    .data_ready (data_ready),
    .frame_err  (fe2),
    .overrun    (ov2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge sclk);
    #1;
  endtask

  task automatic send_bits(input logic [15:0] w, input int n, input bit msb);
    for (int i = 0; i < n; i++) begin
      cs_n = 1'b0;
      mosi = msb ? w[15-i] : w[i];
      tick();
    end
  endtask

  task automatic gap(input int n);
    cs_n = 1'b1;
    mosi = 1'b0;
    repeat (n) tick();
  endtask

  logic [15:0] bb [5];
  int          fe_cnt;

  initial begin
    bb[0] = 16'hFFFF; bb[1] = 16'hFFF0; bb[2] = 16'hFF0F; bb[3] = 16'hF0FF; bb[4] = 16'h0FFF;

    #50;
    check("rst_data_out", {16'h0, d1}, 32'h0);
    check("rst_valid", {31'h0, v1}, 32'h0);
    check("rst_frame_err", {31'h0, fe1}, 32'h0);
    check("rst_overrun", {31'h0, ov1}, 32'h0);
    check("rst_lsb_valid", {31'h0, v2}, 32'h0);
    @(posedge sclk);
    #1;
    reset_n = 1'b1;
    tick();

    send_bits(16'hA5C3, 16, 1'b1);
    check("basic_valid", {31'h0, v1}, 32'h1);
    check("basic_data", {16'h0, d1}, 32'hA5C3);
    check("basic_ferr", {31'h0, fe1}, 32'h0);
    check("basic_ovr", {31'h0, ov1}, 32'h0);
    gap(1);
    check("basic_valid_drop", {31'h0, v1}, 32'h0);
    check("basic_data_hold", {16'h0, d1}, 32'hA5C3);
    gap(1);

    for (int k = 0; k < 5; k++) begin
      send_bits(bb[k], 16, 1'b1);
      check($sformatf("b2b_data%0d", k), {16'h0, d1}, {16'h0, bb[k]});
      check($sformatf("b2b_valid%0d", k), {31'h0, v1}, 32'h1);
      gap(2);
    end

    send_bits(16'hFFC0, 10, 1'b1);
    check("short_no_ferr_yet", {31'h0, fe1}, 32'h0);
    gap(1);
    check("short_ferr", {31'h0, fe1}, 32'h1);
    check("short_no_valid", {31'h0, v1}, 32'h0);
    send_bits(16'h1234, 1, 1'b1);
    check("short_ferr_one_cycle", {31'h0, fe1}, 32'h0);
    send_bits(16'h1234 << 1, 15, 1'b1);
    check("after_short_data", {16'h0, d1}, 32'h1234);
    check("after_short_valid", {31'h0, v1}, 32'h1);
    gap(2);

    send_bits(16'hBEEF, 16, 1'b1);
    check("long_data", {16'h0, d1}, 32'hBEEF);
    check("long_valid", {31'h0, v1}, 32'h1);
    check("long_no_ferr_at_16", {31'h0, fe1}, 32'h0);
    cs_n = 1'b0;
    mosi = 1'b1;
    tick();
    check("long_ferr_cycle17", {31'h0, fe1}, 32'h1);
    fe_cnt = 0;
    for (int j = 0; j < 3; j++) begin
      mosi = j[0];
      tick();
      if (fe1) fe_cnt++;
    end
    check("long_single_ferr", fe_cnt, 32'd0);
    gap(2);
    check("long_data_hold", {16'h0, d1}, 32'hBEEF);

    data_ready = 1'b0;
    send_bits(16'h0001, 16, 1'b1);
    check("ovr_first_valid", {31'h0, v1}, 32'h1);
    check("ovr_first_data", {16'h0, d1}, 32'h0001);
    gap(2);
    check("ovr_valid_held", {31'h0, v1}, 32'h1);
    send_bits(16'h0002, 16, 1'b1);
    check("ovr_pulse", {31'h0, ov1}, 32'h1);
    check("ovr_data_kept", {16'h0, d1}, 32'h0001);
    check("ovr_valid_still", {31'h0, v1}, 32'h1);
    gap(1);
    check("ovr_pulse_once", {31'h0, ov1}, 32'h0);
    data_ready = 1'b1;
    tick();
    check("ovr_valid_drop", {31'h0, v1}, 32'h0);
    check("ovr_data_hold", {16'h0, d1}, 32'h0001);
    gap(1);

    send_bits(16'hFFFF, 8, 1'b1);
    reset_n = 1'b0;
    #1;
    check("midrst_data", {16'h0, d1}, 32'h0);
    check("midrst_valid", {31'h0, v1}, 32'h0);
    cs_n = 1'b1;
    tick();
    tick();
    reset_n = 1'b1;
    tick();
    send_bits(16'h5A5A, 16, 1'b1);
    check("midrst_next_data", {16'h0, d1}, 32'h5A5A);
    check("midrst_next_valid", {31'h0, v1}, 32'h1);
    check("midrst_next_ferr", {31'h0, fe1}, 32'h0);
    gap(2);

    send_bits(16'h0001, 16, 1'b0);
    check("lsb_data", {16'h0, d2}, 32'h0001);
    check("lsb_valid", {31'h0, v2}, 32'h1);
    check("lsb_on_msb_dut", {16'h0, d1}, 32'h8000);
    gap(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
